phaser_in_tap_ctrl: RTL

//  Upstream SYSCLK-domain sequencer for the PHASER_IN control port. Accepts tap-adjust requests:

---
 rtl/phaser_ctrl_pkg.sv | 21 ++
 rtl/phaser_in_step_timer.sv | 32 +++
 rtl/phaser_in_tap_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/phaser_ctrl_pkg.sv
// Shared encodings for the PHASER_IN tap-control sequencer:
// request opcodes, FSM state codes and default widths.
package phaser_ctrl_pkg;

   localparam int unsigned TAP_W_DEF = 6;
   localparam int unsigned CNT_W     = 16;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_STEP   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_READ   = 3'd4;
   localparam logic [2:0] S_RWAIT  = 3'd5;
   localparam logic [2:0] S_RESP   = 3'd6;

endpackage

// File: rtl/phaser_in_step_timer.sv
// Loadable down-counter timing the SETTLE and RWAIT intervals.
// done_o is high while the count sits at zero.
module phaser_in_step_timer
   import phaser_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/phaser_in_tap_ctrl.sv
// SYSCLK-domain sequencer for the PHASER_IN control port: LOAD/INC/DEC/READ
// requests, spaced phaser strobes, one response per request, shadow tap count.
module phaser_in_tap_ctrl
   import phaser_ctrl_pkg::*;
#(
   parameter int unsigned TAP_W         = TAP_W_DEF,
   parameter int unsigned MAX_TAP       = 63,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned READ_LAT      = 2
) (
   input  logic             SYSCLK,
   input  logic             RSTB,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [1:0]       REQ_OP,
   input  logic [TAP_W-1:0] REQ_VAL,
   output logic             RSP_VALID,
   output logic [TAP_W-1:0] RSP_DATA,
   output logic             RSP_ERR,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             COUNTERLOADEN,
   output logic [TAP_W-1:0] COUNTERLOADVAL,
   output logic             COUNTERREADEN,
   output logic             FINEENABLE,
   output logic             FINEINC,
   input  logic [TAP_W-1:0] COUNTERREADVAL,
   input  logic             FINEOVERFLOW
);

   localparam logic [TAP_W-1:0] MAX_T     = TAP_W'(MAX_TAP);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RWAIT_LD  = CNT_W'(READ_LAT - 1);

   logic [2:0]       state_q, state_d;
   logic [TAP_W-1:0] cur_q, cur_d;
   logic [TAP_W-1:0] rem_q, rem_d;
   logic [TAP_W-1:0] lval_q, lval_d;
   logic [TAP_W-1:0] rsp_data_q, rsp_data_d;
   logic             inc_q, inc_d;
   logic             err_q, err_d;
   logic             ready_q, loaden_q, readen_q, fineen_q, rsp_valid_q, rsp_err_q;

   logic             tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val;
   logic             lim_inc, lim_dec, req_inc;

   assign lim_inc = (cur_q >= MAX_T);
   assign lim_dec = (cur_q == '0);
   assign req_inc = (REQ_OP == OP_INC);

   phaser_in_step_timer u_timer (
      .clk        (SYSCLK),
      .rst_n      (RSTB),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rem_d      = rem_q;
      lval_d     = lval_q;
      inc_d      = inc_q;
      err_d      = err_q;
      rsp_data_d = rsp_data_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      case (state_q)
         S_IDLE: begin
            if (REQ_VALID && ready_q) begin
               err_d = 1'b0;
               case (REQ_OP)
                  OP_LOAD: begin
                     state_d = S_LOAD;
                     if ({1'b0, REQ_VAL} > {1'b0, MAX_T}) begin
                        cur_d = MAX_T;
                        err_d = 1'b1;
                     end else begin
                        cur_d = REQ_VAL;
                     end
                     lval_d = cur_d;
                  end
                  OP_INC, OP_DEC: begin
                     inc_d = req_inc;
                     if (REQ_VAL == '0) begin
                        state_d = S_RESP;
                     end else if (req_inc ? lim_inc : lim_dec) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                     end else begin
                        state_d = S_STEP;
                        rem_d   = REQ_VAL - TAP_W'(1);
                        cur_d   = req_inc ? cur_q + TAP_W'(1) : cur_q - TAP_W'(1);
                     end
                  end
                  default: state_d = S_READ;
               endcase
            end
         end
         S_LOAD: state_d = S_RESP;
         S_STEP: begin
            state_d  = S_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
         end
         S_SETTLE: begin
            // Overflow is checked on every settle cycle, ahead of the step decision.
            if (FINEOVERFLOW) begin
               state_d = S_RESP;
               err_d   = 1'b1;
            end else if (tmr_done) begin
               if (rem_q == '0) begin
                  state_d = S_RESP;
               end else if (inc_q ? lim_inc : lim_dec) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_STEP;
                  rem_d   = rem_q - TAP_W'(1);
                  cur_d   = inc_q ? cur_q + TAP_W'(1) : cur_q - TAP_W'(1);
               end
            end
         end
         S_READ: begin
            state_d  = S_RWAIT;
            tmr_load = 1'b1;
            tmr_val  = RWAIT_LD;
         end
         S_RWAIT: if (tmr_done) state_d = S_RESP;
         S_RESP: begin
            state_d = S_IDLE;
            inc_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_RESP)
         rsp_data_d = (state_q == S_RWAIT) ? COUNTERREADVAL : cur_d;
   end

   // Strobes are registered decodes of the next state, so they line up with the state they mark.
   always_ff @(posedge SYSCLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         rem_q       <= '0;
         lval_q      <= '0;
         rsp_data_q  <= '0;
         inc_q       <= 1'b0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         loaden_q    <= 1'b0;
         readen_q    <= 1'b0;
         fineen_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rem_q       <= rem_d;
         lval_q      <= lval_d;
         rsp_data_q  <= rsp_data_d;
         inc_q       <= inc_d;
         err_q       <= err_d;
         ready_q     <= (state_d == S_IDLE);
         loaden_q    <= (state_d == S_LOAD);
         readen_q    <= (state_d == S_READ);
         fineen_q    <= (state_d == S_STEP);
         rsp_valid_q <= (state_d == S_RESP);
         rsp_err_q   <= (state_d == S_RESP) && err_d;
      end
   end

   assign REQ_READY      = ready_q;
   assign RSP_VALID      = rsp_valid_q;
   assign RSP_DATA       = rsp_data_q;
   assign RSP_ERR        = rsp_err_q;
   assign CUR_TAP        = cur_q;
   assign COUNTERLOADEN  = loaden_q;
   assign COUNTERLOADVAL = lval_q;
   assign COUNTERREADEN  = readen_q;
   assign FINEENABLE     = fineen_q;
   assign FINEINC        = inc_q;

endmodule
